// File: rtl/oka32_seq.sv
// 32x32 carry-less multiply sequencer: three passes (low, high, middle) over a
// shared external 16-bit carry-less multiplier, Karatsuba recombination in P2.
module oka32_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [62:0]      y,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [30:0]      mul_y
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] ar;
    logic [31:0] br;
    logic [30:0] z0;
    logic [30:0] z2;
    logic [30:0] mid;

    // Middle term only consumed in P2, so mul_y outside the passes never reaches a register.
    assign mid = mul_y ^ z0 ^ z2;

    // mul_a/mul_b are loaded on entry to each pass so they are valid for the whole pass cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            op_count  <= '0;
            ar        <= '0;
            br        <= '0;
            z0        <= '0;
            z2        <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar       <= a;
                        br       <= b;
                        mul_a    <= a[15:0];
                        mul_b    <= b[15:0];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= P0;
                    end
                end
                P0: begin
                    z0    <= mul_y;
                    mul_a <= ar[31:16];
                    mul_b <= br[31:16];
                    state <= P1;
                end
                P1: begin
                    z2    <= mul_y;
                    mul_a <= ar[15:0] ^ ar[31:16];
                    mul_b <= br[15:0] ^ br[31:16];
                    state <= P2;
                end
                P2: begin
                    y         <= 63'({z2, 32'b0}) ^ 63'({mid, 16'b0}) ^ 63'(z0);
                    out_valid <= 1'b1;
                    mul_a     <= '0;
                    mul_b     <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    mul_a     <= '0;
                    mul_b     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oka32_seq.sv
// Bench for oka32_seq: bit-serial carry-less models for the shared multiplier
// and the full product, with a result scoreboard fed at operand acceptance.
module tb_oka32_seq;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      a = '0;
    logic [31:0]      b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [62:0]      y;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [30:0]      mul_y;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [62:0]      sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    oka32_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .busy     (busy),
        .op_count (op_count),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_y    (mul_y)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] clmul16(input logic [15:0] x, input logic [15:0] z);
        logic [30:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (z[i]) r = r ^ (31'(x) << i);
        return r;
    endfunction

    function automatic logic [62:0] clmul32(input logic [31:0] x, input logic [31:0] z);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (z[i]) r = r ^ (63'(x) << i);
        return r;
    endfunction

    always_comb mul_y = clmul16(mul_a, mul_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on delivery; op_count tracked every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("op_count", 64'(op_count), 64'(exp_cnt));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    check("y_sb", 64'(y), 64'(sb.pop_front()));
                end
                exp_cnt = exp_cnt + CNT_W'(1);
            end
            if (in_valid && in_ready) sb.push_back(clmul32(a, b));
        end
    end

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (n == 20) check("accept_timeout", 64'(0), 64'(1));
        a = va; b = vb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (n == 20) check("result_timeout", 64'(0), 64'(1));
        tick();
    endtask

    initial begin
        int           n;
        logic [62:0]  held;
        logic [1:0]   wrap_seq [5];
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_op_count", 64'(op_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        rst = 1'b0;
        tick();

        // Reset in P1 discards the operation (op_count is 0 here either way).
        a = 32'h5; b = 32'h7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_op_count", 64'(op_count), 64'(0));
        run_op(32'h2, 32'h3);
        check("y_2x3", 64'(y), 64'h6);

        // Cycle-by-cycle pass sequence for 3*3.
        check("idle_mul_a", 64'(mul_a), 64'(0));
        a = 32'h3; b = 32'h3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 32'hdead_beef; b = 32'hffff_0000;
        check("p0_in_ready", 64'(in_ready), 64'(0));
        check("p0_busy", 64'(busy), 64'(1));
        check("p0_mul", 64'({mul_a, mul_b}), 64'({16'h3, 16'h3}));
        tick();
        check("p1_mul", 64'({mul_a, mul_b}), 64'(0));
        tick();
        check("p2_mul", 64'({mul_a, mul_b}), 64'({16'h3, 16'h3}));
        check("p2_out_valid", 64'(out_valid), 64'(0));
        tick();
        check("done_out_valid", 64'(out_valid), 64'(1));
        check("done_y", 64'(y), 64'h5);
        check("done_mul", 64'({mul_a, mul_b}), 64'(0));
        tick();
        check("post_out_valid", 64'(out_valid), 64'(0));
        check("post_in_ready", 64'(in_ready), 64'(1));
        check("post_y_held", 64'(y), 64'h5);

        run_op(32'hffff_ffff, 32'h1);
        check("y_ones_x1", 64'(y), 64'h0_ffff_ffff);
        run_op(32'h0001_0000, 32'h0001_0000);
        check("y_x16sq", 64'(y), 64'h1_0000_0000);
        run_op(32'h8000_0000, 32'h8000_0000);
        check("y_x31sq", 64'(y), 64'h4000_0000_0000_0000);
        run_op(32'hffff_ffff, 32'hffff_ffff);
        check("y_ones_sq", 64'(y), 64'h5555_5555_5555_5555);

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        a = 32'h1234_5678; b = 32'h9abc_def0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (n == 20) check("bp_timeout", 64'(0), 64'(1));
        held = clmul32(32'h1234_5678, 32'h9abc_def0);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_y", 64'(y), 64'(held));
            in_valid = i[0]; a = $urandom; b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_rel_in_ready", 64'(in_ready), 64'(1));
        check("bp_rel_out_valid", 64'(out_valid), 64'(0));

        // Counter wrap from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            run_op($urandom, $urandom);
            check("wrap_count", 64'(op_count), 64'(wrap_seq[i]));
        end

        for (int i = 0; i < 1000; i++) run_op($urandom, $urandom);

        tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
